// File: rtl/imm_pkg.sv
// Shared encodings for the ID/EX immediate generator stage.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_U    = 3'b000,
    IMM_J    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_I    = 3'b100,
    IMM_SFT  = 3'b101,
    IMM_ZIMM = 3'b110,
    IMM_IU   = 3'b111
  } imm_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus between ID (master) and the immediate stage (slave) and on to EX.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_bits;
  logic [2:0]       imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             shamt_err;

  modport master (
    output in_valid, in_bits, imm_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, shamt_err
  );

  modport slave (
    input  in_valid, in_bits, imm_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, shamt_err
  );
endinterface

// File: rtl/imm_format_decode.sv
// Combinational instr[31:7] -> XLEN immediate decode, plus illegal-shamt flag.
module imm_format_decode import imm_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     in_i,
  input  imm_sel_e        sel_i,
  output logic [XLEN-1:0] imm_o,
  output logic            shamt_err_o
);
  logic sgn;
  assign sgn = in_i[24];

  // Signed formats preload the sign across XLEN, then overwrite the field bits.
  always_comb begin
    imm_o       = '0;
    shamt_err_o = 1'b0;
    case (sel_i)
      IMM_U: begin
        imm_o       = {XLEN{sgn}};
        imm_o[31:0] = {in_i[24:5], 12'b0};
      end
      IMM_J: begin
        imm_o       = {XLEN{sgn}};
        imm_o[20:0] = {in_i[24], in_i[12:5], in_i[13], in_i[23:14], 1'b0};
      end
      IMM_S: begin
        imm_o       = {XLEN{sgn}};
        imm_o[11:0] = {in_i[24:18], in_i[4:0]};
      end
      IMM_B: begin
        imm_o       = {XLEN{sgn}};
        imm_o[12:0] = {in_i[24], in_i[0], in_i[23:18], in_i[4:1], 1'b0};
      end
      IMM_I: begin
        imm_o       = {XLEN{sgn}};
        imm_o[11:0] = in_i[24:13];
      end
      IMM_SFT: begin
        if (XLEN == 32) begin
          imm_o[4:0]  = in_i[17:13];
          shamt_err_o = in_i[18];
        end else begin
          imm_o[5:0]  = in_i[18:13];
        end
      end
      IMM_ZIMM: imm_o[4:0]  = in_i[12:8];
      IMM_IU:   imm_o[11:0] = in_i[24:13];
      default:  imm_o       = '0;
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer; decode happens before storage.
module imm_gen_stage import imm_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  imm_gen_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  state_e          state_q;
  entry_t          main_q, skid_q, entry_d;
  logic            in_ready_q;
  logic            accept, pop;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_format_decode #(.XLEN(XLEN)) u_dec (
    .in_i        (bus.in_bits),
    .sel_i       (imm_sel_e'(bus.imm_sel)),
    .imm_o       (dec_imm),
    .shamt_err_o (dec_err)
  );

  assign entry_d = '{imm: dec_imm, tag: bus.in_tag, err: dec_err};
  assign accept  = bus.in_valid & in_ready_q;
  assign pop     = (state_q != EMPTY) & bus.out_ready;

  // Flush only clears occupancy; stale main_q is masked by out_valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_q  <= entry_d;
          state_q <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= entry_d;
          end else if (accept) begin
            skid_q     <= entry_d;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: if (pop) begin
          main_q     <= skid_q;
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_imm   = main_q.imm;
  assign bus.out_tag   = main_q.tag;
  assign bus.shamt_err = main_q.err;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives XLEN=32 and XLEN=64 stages in lockstep against a queue-based reference model.
module tb_imm_gen_stage;
  logic clk = 1'b0;
  logic rst_n, flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if64));

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];

  logic        cur_valid, cur_ordy;
  logic [31:0] cur_instr, cur_tag;
  logic [2:0]  cur_sel;

  function automatic logic [63:0] sext(logic [63:0] v, int w);
    logic [63:0] m;
    m = 64'hFFFF_FFFF_FFFF_FFFF << w;
    return v[w-1] ? (v | m) : (v & ~m);
  endfunction

  // Reference decode straight from RISC-V instruction-field definitions.
  task automatic ref_decode(input logic [31:0] ins, input logic [2:0] sel, input int xlen,
                            output logic [63:0] imm, output logic err);
    err = 1'b0;
    case (sel)
      3'd0: imm = sext({32'b0, ins[31:12], 12'b0}, 32);
      3'd1: imm = sext({43'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      3'd2: imm = sext({52'b0, ins[31:25], ins[11:7]}, 12);
      3'd3: imm = sext({51'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      3'd4: imm = sext({52'b0, ins[31:20]}, 12);
      3'd5: begin
        if (xlen == 32) begin
          imm = {59'b0, ins[24:20]};
          err = ins[25];
        end else begin
          imm = {58'b0, ins[25:20]};
        end
      end
      3'd6: imm = {59'b0, ins[19:15]};
      default: imm = {52'b0, ins[31:20]};
    endcase
    if (xlen == 32) imm[63:32] = 32'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [31:0] tag);
    cur_valid = v; cur_instr = ins; cur_sel = sel; cur_tag = tag;
    if32.in_valid = v; if32.in_bits = ins[31:7]; if32.imm_sel = sel; if32.in_tag = tag;
    if64.in_valid = v; if64.in_bits = ins[31:7]; if64.imm_sel = sel; if64.in_tag = tag;
  endtask

  task automatic set_ordy(input logic r);
    cur_ordy = r;
    if32.out_ready = r;
    if64.out_ready = r;
  endtask

  task automatic check_outputs();
    chk("rdy32", {63'b0, if32.in_ready},  {63'b0, q32.size() < 2});
    chk("vld32", {63'b0, if32.out_valid}, {63'b0, q32.size() > 0});
    if (q32.size() > 0) begin
      chk("imm32", {32'b0, if32.out_imm},   q32[0].imm);
      chk("tag32", {32'b0, if32.out_tag},   {32'b0, q32[0].tag});
      chk("err32", {63'b0, if32.shamt_err}, {63'b0, q32[0].err});
    end
    chk("rdy64", {63'b0, if64.in_ready},  {63'b0, q64.size() < 2});
    chk("vld64", {63'b0, if64.out_valid}, {63'b0, q64.size() > 0});
    if (q64.size() > 0) begin
      chk("imm64", if64.out_imm,            q64[0].imm);
      chk("tag64", {32'b0, if64.out_tag},   {32'b0, q64[0].tag});
      chk("err64", {63'b0, if64.shamt_err}, {63'b0, q64[0].err});
    end
  endtask

  task automatic chk_reset();
    chk("rst_vld32", {63'b0, if32.out_valid}, 64'd0);
    chk("rst_rdy32", {63'b0, if32.in_ready},  64'd1);
    chk("rst_imm32", {32'b0, if32.out_imm},   64'd0);
    chk("rst_tag32", {32'b0, if32.out_tag},   64'd0);
    chk("rst_err32", {63'b0, if32.shamt_err}, 64'd0);
    chk("rst_vld64", {63'b0, if64.out_valid}, 64'd0);
    chk("rst_imm64", if64.out_imm,            64'd0);
    chk("rst_rdy64", {63'b0, if64.in_ready},  64'd1);
  endtask

  // Check current outputs, advance the model by this cycle's inputs, then clock.
  task automatic step();
    ent_t e32, e64;
    logic acc, pop;
    check_outputs();
    ref_decode(cur_instr, cur_sel, 32, e32.imm, e32.err);
    ref_decode(cur_instr, cur_sel, 64, e64.imm, e64.err);
    e32.tag = cur_tag;
    e64.tag = cur_tag;
    if (!rst_n || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      acc = cur_valid && (q32.size() < 2);
      pop = (q32.size() > 0) && cur_ordy;
      if (pop) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(e32);
        q64.push_back(e64);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    set_ordy(1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_reset();

    // Sign-extended I immediate of all ones, single-cycle valid pulse.
    rst_n = 1'b1;
    set_ordy(1'b1);
    drive(1'b1, 32'hFFF0_0013, 3'd4, 32'h11);
    step();
    chk("t1_imm", {32'b0, if32.out_imm}, 64'hFFFF_FFFF);
    drive(1'b0, $urandom, 3'($urandom), $urandom);
    step();
    step();

    // Every format on one instruction word, back to back.
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 32'hFEDC_BA98, 3'(s), 32'h100 + s);
      step();
    end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    step();

    // Shift-amount legality per XLEN.
    drive(1'b1, 32'h03F0_0013, 3'd5, 32'h55);
    step();
    chk("t3_err32", {63'b0, if32.shamt_err}, 64'd1);
    chk("t3_imm64", if64.out_imm, 64'h3F);
    chk("t3_err64", {63'b0, if64.shamt_err}, 64'd0);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    step();

    // Stall with three offers: buffer fills at two, third waits, order preserved.
    set_ordy(1'b0);
    for (int t = 1; t <= 3; t++) begin
      drive(1'b1, $urandom, 3'($urandom), t);
      step();
    end
    chk("t4_rdy", {63'b0, if32.in_ready}, 64'd0);
    step();
    set_ordy(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1'b0, 32'h0, 3'd0, 32'h0);
      step();
    end

    // Flush while full with a concurrent offer.
    set_ordy(1'b0);
    drive(1'b1, $urandom, 3'd4, 32'hA1);
    step();
    drive(1'b1, $urandom, 3'd3, 32'hA2);
    step();
    drive(1'b1, $urandom, 3'd2, 32'hDEAD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    chk("t5_vld", {63'b0, if32.out_valid}, 64'd0);
    chk("t5_rdy", {63'b0, if32.in_ready}, 64'd1);
    set_ordy(1'b1);
    step();
    step();

    // Reset dominates flush while full.
    set_ordy(1'b0);
    drive(1'b1, $urandom, 3'd1, 32'hB1);
    step();
    drive(1'b1, $urandom, 3'd0, 32'hB2);
    step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    chk_reset();
    rst_n = 1'b1;
    flush = 1'b0;

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      set_ordy($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 1) == 1, $urandom, 3'($urandom), $urandom);
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    set_ordy(1'b1);
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
